// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the programmable clock divider.
//   CLKDIV_CNT_W       default divisor/counter width
//   CLKDIV_DEFAULT_DIV divisor applied at reset (100 MHz -> 10 kHz)
//   CLKDIV_MIN_DIV     smallest legal divisor; smaller loads are clamped up
//   clamp_div()        raise a divisor to the legal minimum
//   half_high()        high-phase length of a period, ceil(d/2)
package clkdiv_pkg;

    localparam int unsigned CLKDIV_CNT_W       = 24;
    localparam int unsigned CLKDIV_DEFAULT_DIV = 10000;
    localparam int unsigned CLKDIV_MIN_DIV     = 2;

    // Raise a requested divisor to the legal minimum.
    function automatic logic [31:0] clamp_div(input logic [31:0] v, input logic [31:0] min_div);
        return (v < min_div) ? min_div : v;
    endfunction

    // ceil(d/2) written as (d>>1)+d[0] so the all-ones divisor cannot overflow.
    function automatic logic [31:0] half_high(input logic [31:0] d);
        return (d >> 1) + {31'd0, d[0]};
    endfunction

endpackage

// File: rtl/clock_divider_prog.sv
// Runtime-programmable clock divider: ~50% duty divided clock-enable square
// wave plus a one-cycle tick coincident with each rising edge of it.
// A divisor loaded while running is held in a shadow register and applied at
// the next period boundary so no period is ever truncated or stretched.
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   en           run enable; low holds the counter primed at div-1
//   div_val      new divisor value (clamped to MIN_DIV)
//   div_load     one-cycle strobe capturing div_val
//   divided_clk  registered square wave, period = active divisor
//   tick         registered one-cycle pulse on each divided_clk rise
//   pending      a loaded divisor is waiting for a period boundary
//   period_cnt   (only with CLKDIV_PERIOD_CNT_EN) free-running count of ticks
// Configuration macro: CLKDIV_PERIOD_CNT_EN adds the period_cnt output.
// CNT_W is limited to 32 bits by the package helpers.
module clock_divider_prog
    import clkdiv_pkg::*;
#(
    parameter int unsigned CNT_W       = CLKDIV_CNT_W,
    parameter int unsigned DEFAULT_DIV = CLKDIV_DEFAULT_DIV,
    parameter int unsigned MIN_DIV     = CLKDIV_MIN_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_load,
    output logic             divided_clk,
    output logic             tick,
    output logic             pending
`ifdef CLKDIV_PERIOD_CNT_EN
    ,
    output logic [15:0]      period_cnt
`endif
);

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pending_q, pending_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;

    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] next_div;
    logic             wrap;

    // Next-state: counter, active/shadow divisor and output levels.
    always_comb begin
        load_val  = CNT_W'(clamp_div(32'(div_val), 32'(MIN_DIV)));
        // Divisor that would take over at a boundary; a fresh load beats the shadow.
        next_div  = div_load ? load_val : (pending_q ? pend_q : div_q);
        wrap      = (cnt_q == div_q - ONE);

        div_d     = div_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        pending_d = pending_q;
        clk_d     = 1'b0;
        tick_d    = 1'b0;

        if (!en) begin
            // Idle: adopt any new divisor now and prime so the next run starts on a tick.
            div_d     = next_div;
            cnt_d     = next_div - ONE;
            pending_d = 1'b0;
        end else begin
            if (wrap) begin
                div_d     = next_div;
                cnt_d     = '0;
                pending_d = 1'b0;
            end else begin
                cnt_d = cnt_q + ONE;
                if (div_load) begin
                    pend_d    = load_val;
                    pending_d = 1'b1;
                end
            end
            clk_d  = (cnt_d < CNT_W'(half_high(32'(div_d))));
            tick_d = (cnt_d == '0);
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q     <= DEF_DIV;
            cnt_q     <= DEF_DIV - ONE;
            pend_q    <= '0;
            pending_q <= 1'b0;
            clk_q     <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            pending_q <= pending_d;
            clk_q     <= clk_d;
            tick_q    <= tick_d;
        end
    end

    assign divided_clk = clk_q;
    assign tick        = tick_q;
    assign pending     = pending_q;

`ifdef CLKDIV_PERIOD_CNT_EN
    logic [15:0] period_cnt_q;

    // Counts cycles with tick high; wraps naturally, only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            period_cnt_q <= '0;
        end else if (tick_q) begin
            period_cnt_q <= period_cnt_q + 16'd1;
        end
    end

    assign period_cnt = period_cnt_q;
`endif

endmodule

// File: tb/tb_clock_divider_prog.sv
// Self-checking bench for clock_divider_prog: directed scenarios plus a
// randomized run checked against a cycle-level reference model.
module tb_clock_divider_prog;

    localparam int unsigned W   = 24;
    localparam int          DEF = 10000;
    localparam int          MIN = 2;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [W-1:0] div_val;
    logic         div_load;
    logic         divided_clk;
    logic         tick;
    logic         pending;
`ifdef CLKDIV_PERIOD_CNT_EN
    logic [15:0]  period_cnt;
`endif

    int total;
    int bad;

    // Reference model state: active divisor, position in period, shadow divisor.
    int m_div;
    int m_pos;
    int m_pv;
    bit m_pending;
    bit m_clk;
    bit m_tick;
    int m_pcnt;

    clock_divider_prog dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .div_val     (div_val),
        .div_load    (div_load),
        .divided_clk (divided_clk),
        .tick        (tick),
        .pending     (pending)
`ifdef CLKDIV_PERIOD_CNT_EN
        ,
        .period_cnt  (period_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_step(input bit r, input bit e, input bit ld, input int v);
        int lv;
        if (!r) begin
            m_div = DEF; m_pos = DEF - 1; m_pv = 0;
            m_pending = 0; m_clk = 0; m_tick = 0; m_pcnt = 0;
        end else begin
            if (m_tick) m_pcnt = (m_pcnt + 1) % 65536;
            lv = (v < MIN) ? MIN : v;
            if (!e) begin
                if (ld) m_div = lv;
                else if (m_pending) m_div = m_pv;
                m_pending = 0; m_pos = m_div - 1; m_clk = 0; m_tick = 0;
            end else if (m_pos == m_div - 1) begin
                if (ld) m_div = lv;
                else if (m_pending) m_div = m_pv;
                m_pending = 0; m_pos = 0; m_clk = 1; m_tick = 1;
            end else begin
                m_pos++;
                if (ld) begin m_pv = lv; m_pending = 1; end
                m_clk  = (m_pos < (m_div + 1) / 2);
                m_tick = 0;
            end
        end
    endtask

    // Drive one clock with the given inputs; returns #1 after the edge.
    task automatic cyc(input bit r, input bit e, input bit ld, input int v);
        rst_n = r; en = e; div_load = ld; div_val = W'(v);
        @(posedge clk);
        #1;
        model_step(r, e, ld, v);
        div_load = 1'b0;
    endtask

    task automatic test_reset();
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        total++;
        if ({divided_clk, tick, pending} !== 3'b000) begin
            bad++;
            $display("FAIL reset_state: got clk/tick/pend=%b want 000", {divided_clk, tick, pending});
        end
    endtask

    task automatic test_default_div();
        int hi_cnt, hi_first, tk_cnt, rise_err, model_err;
        logic prev;
        cyc(1, 1, 0, 0);
        total++;
        if ({divided_clk, tick} !== 2'b11) begin
            bad++;
            $display("FAIL default_first_edge: got clk/tick=%b want 11", {divided_clk, tick});
        end
        prev = divided_clk; hi_cnt = 1; hi_first = 1; tk_cnt = 1; rise_err = 0; model_err = 0;
        for (int i = 1; i < 20000; i++) begin
            cyc(1, 1, 0, 0);
            if (divided_clk === 1'b1) begin
                hi_cnt++;
                if (i < 10000) hi_first++;
            end
            if (tick === 1'b1) tk_cnt++;
            if ((divided_clk && !prev) !== tick) rise_err++;
            if (i == 10000 && tick !== 1'b1) rise_err++;
            if ({divided_clk, tick, pending} !== {m_clk, m_tick, m_pending}) model_err++;
            prev = divided_clk;
        end
        total++;
        if (hi_first !== 5000) begin
            bad++; $display("FAIL default_high_phase: got %0d want 5000", hi_first);
        end
        total++;
        if (hi_cnt !== 10000) begin
            bad++; $display("FAIL default_high_total: got %0d want 10000", hi_cnt);
        end
        total++;
        if (tk_cnt !== 2) begin
            bad++; $display("FAIL default_tick_count: got %0d want 2", tk_cnt);
        end
        total++;
        if (rise_err !== 0) begin
            bad++; $display("FAIL default_tick_align: got %0d misaligned want 0", rise_err);
        end
        total++;
        if (model_err !== 0) begin
            bad++; $display("FAIL default_model: got %0d mismatching cycles want 0", model_err);
        end
    endtask

    task automatic test_start();
        logic [9:0] oc, ot;
        logic       op;
        cyc(1, 0, 1, 5);
        total++;
        if ({divided_clk, tick, pending} !== 3'b000) begin
            bad++;
            $display("FAIL start_idle: got clk/tick/pend=%b want 000", {divided_clk, tick, pending});
        end
        cyc(1, 0, 0, 0);
        op = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1, 1, 0, 0);
            oc[9-i] = divided_clk; ot[9-i] = tick; op = op | pending;
        end
        total++;
        if (oc !== 10'b1110011100) begin
            bad++; $display("FAIL start_div5_clk: got %b want 1110011100", oc);
        end
        total++;
        if (ot !== 10'b1000010000) begin
            bad++; $display("FAIL start_div5_tick: got %b want 1000010000", ot);
        end
        total++;
        if (op !== 1'b0) begin
            bad++; $display("FAIL start_pending: got %b want 0", op);
        end
    endtask

    task automatic test_pending_switch();
        logic [11:0] oc, ot, op;
        cyc(1, 0, 1, 4);
        for (int i = 0; i < 12; i++) begin
            cyc(1, 1, (i == 2), 7);
            oc[11-i] = divided_clk; ot[11-i] = tick; op[11-i] = pending;
        end
        total++;
        if (oc !== 12'b110011110001) begin
            bad++; $display("FAIL pend_clk: got %b want 110011110001", oc);
        end
        total++;
        if (ot !== 12'b100010000001) begin
            bad++; $display("FAIL pend_tick: got %b want 100010000001", ot);
        end
        total++;
        if (op !== 12'b001100000000) begin
            bad++; $display("FAIL pend_flag: got %b want 001100000000", op);
        end
    endtask

    task automatic test_clamp();
        logic [5:0] oc, ot;
        for (int k = 0; k < 2; k++) begin
            cyc(1, 0, 1, k);
            for (int i = 0; i < 6; i++) begin
                cyc(1, 1, 0, 0);
                oc[5-i] = divided_clk; ot[5-i] = tick;
            end
            total++;
            if (oc !== 6'b101010) begin
                bad++; $display("FAIL clamp_load%0d_clk: got %b want 101010", k, oc);
            end
            total++;
            if (ot !== 6'b101010) begin
                bad++; $display("FAIL clamp_load%0d_tick: got %b want 101010", k, ot);
            end
        end
    endtask

    task automatic test_reset_midrun();
        int errs;
        cyc(1, 0, 1, 6);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 1, 9);
        total++;
        if (pending !== 1'b1) begin
            bad++; $display("FAIL rstmid_pending_set: got %b want 1", pending);
        end
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(0, 1, 0, 0);
        total++;
        if ({divided_clk, tick, pending} !== 3'b000) begin
            bad++;
            $display("FAIL rstmid_state: got clk/tick/pend=%b want 000", {divided_clk, tick, pending});
        end
        cyc(1, 1, 0, 0);
        total++;
        if ({divided_clk, tick} !== 2'b11) begin
            bad++; $display("FAIL rstmid_first_tick: got clk/tick=%b want 11", {divided_clk, tick});
        end
        // With the default divisor restored the high phase lasts 5000 cycles.
        errs = 0;
        for (int i = 0; i < 9; i++) begin
            cyc(1, 1, 0, 0);
            if ({divided_clk, tick} !== 2'b10) errs++;
        end
        total++;
        if (errs !== 0) begin
            bad++; $display("FAIL rstmid_default_div: got %0d wrong cycles want 0", errs);
        end
    endtask

    task automatic test_random();
        bit r, e, ld;
        int v;
        for (int i = 0; i < 4000; i++) begin
            r  = ($urandom_range(0, 199) != 0);
            e  = ($urandom_range(0, 9) != 0);
            ld = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 49) == 0) v = int'($urandom & 32'h00FF_FFFF);
            else v = int'($urandom_range(0, 12));
            cyc(r, e, ld, v);
            total++;
            if ({divided_clk, tick, pending} !== {m_clk, m_tick, m_pending}) begin
                bad++;
                $display("FAIL random_cycle%0d: got clk/tick/pend=%b want %b", i,
                         {divided_clk, tick, pending}, {m_clk, m_tick, m_pending});
            end
`ifdef CLKDIV_PERIOD_CNT_EN
            total++;
            if (period_cnt !== 16'(m_pcnt)) begin
                bad++;
                $display("FAIL random_period_cnt%0d: got %0d want %0d", i, period_cnt, m_pcnt);
            end
`endif
        end
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; en = 1'b0; div_load = 1'b0; div_val = '0;
        model_step(0, 0, 0, 0);
        test_reset();
        test_default_div();
        test_start();
        test_pending_switch();
        test_clamp();
        test_reset_midrun();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
